// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and lane helpers for the data memory controller
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DMEM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Size field is funct3[1:0]; sign/unsigned variants share the same lanes.
  function automatic logic [DMEM_LANES-1:0] lane_mask(input logic [1:0] size);
    case (size)
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - extends 4 raw little-endian bytes per load funct3
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_bytes,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_bytes;
    case (i_funct3)
      F3_B:    o_data = {{24{i_bytes[7]}}, i_bytes[7:0]};
      F3_H:    o_data = {{16{i_bytes[15]}}, i_bytes[15:0]};
      F3_BU:   o_data = {24'd0, i_bytes[7:0]};
      F3_HU:   o_data = {16'd0, i_bytes[15:0]};
      default: o_data = i_bytes;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-addressable data memory with req/resp handshake and wait states
// Optional: DMEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e r_state, w_next;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [7:0]            r_mem [DEPTH];

  logic                  w_req_ready, w_resp_valid;
  logic                  w_acc_write;
  logic [2:0]            w_acc_funct3;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [31:0]           w_acc_wdata;
  logic                  w_misal, w_legal, w_enter_resp, w_mem_we;
  logic [DMEM_LANES-1:0] w_mask;
  logic [ADDR_WIDTH-1:0] w_ba [DMEM_LANES];
  logic [31:0]           w_raw, w_ld;

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_acc_write  = req_write;
      w_acc_funct3 = req_funct3;
      w_acc_addr   = req_addr[ADDR_WIDTH-1:0];
      w_acc_wdata  = req_wdata;
    end else begin
      w_acc_write  = r_write;
      w_acc_funct3 = r_funct3;
      w_acc_addr   = r_addr;
      w_acc_wdata  = r_wdata;
    end
  end

  always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
    w_misal = ((w_acc_funct3[1:0] == 2'b01) && w_acc_addr[0]) ||
              ((w_acc_funct3[1:0] == 2'b10) && (w_acc_addr[1:0] != 2'b00));
`else
    w_misal = 1'b0;
`endif
    w_legal = 1'b0;
    case (w_acc_funct3)
      F3_B, F3_H, F3_W: w_legal = 1'b1;
      F3_BU, F3_HU:     w_legal = !w_acc_write;
      default:          w_legal = 1'b0;
    endcase
    w_legal = w_legal && !w_misal;
    w_mask  = lane_mask(w_acc_funct3[1:0]);
  end

  // Lane addresses wrap naturally at the top of the decoded space.
  always_comb begin
    for (int k = 0; k < DMEM_LANES; k++) begin
      w_ba[k]          = w_acc_addr + ADDR_WIDTH'(k);
      w_raw[8*k +: 8]  = r_mem[w_ba[k]];
    end
  end

  dmem_load_align u_load_align (
    .i_bytes  (w_raw),
    .i_funct3 (w_acc_funct3),
    .o_data   (w_ld)
  );

  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (r_state != ST_RESP) && (w_next == ST_RESP);
  assign w_mem_we     = rst_n && w_enter_resp && w_acc_write && w_legal;
  assign req_ready    = w_req_ready;
  assign resp_valid   = w_resp_valid;
  assign resp_rdata   = r_rdata;
  assign resp_err     = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && req_valid) begin
        r_cnt    <= CNT_INIT;
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[ADDR_WIDTH-1:0];
        r_wdata  <= req_wdata;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_legal && !w_acc_write) ? w_ld : 32'd0;
        r_err   <= !w_legal;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DMEM_LANES; k++) begin
      if (w_mem_we && w_mask[k]) r_mem[w_ba[k]] <= w_acc_wdata[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - randomized bench for data_memory_ctrl at zero and three wait states
module tb_data_memory_ctrl;

  localparam int WC = 3;

  logic        clk = 1'b0;
  logic [1:0]  rst_n_v, vld, rrdy, rr, rv, re;
  logic        wr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, rd0, rd3;

  logic [7:0]  mdl [65536];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .req_valid(vld[0]), .req_ready(rr[0]),
    .req_write(wr), .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv[0]), .resp_ready(rrdy[0]), .resp_rdata(rd0), .resp_err(re[0])
  );

  data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .WAIT_CYCLES(WC)) u_dut3 (
    .clk(clk), .rst_n(rst_n_v[1]), .req_valid(vld[1]), .req_ready(rr[1]),
    .req_write(wr), .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv[1]), .resp_ready(rrdy[1]), .resp_rdata(rd3), .resp_err(re[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_rd(input int d);
    return (d == 0) ? rd0 : rd3;
  endfunction

  function automatic bit legal(input bit w, input logic [2:0] f, input logic [31:0] a);
    bit ok;
    ok = (f == 3'd0 || f == 3'd1 || f == 3'd2) || (!w && (f == 3'd4 || f == 3'd5));
`ifdef DMEM_MISALIGN_TRAP_EN
    if (f[1:0] == 2'd1 && a[0]) ok = 1'b0;
    if (f[1:0] == 2'd2 && a[1:0] != 2'd0) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic int nbytes(input logic [2:0] f);
    return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f, input logic [31:0] a);
    int n = nbytes(f);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mdl[(a + k) & 32'hFFFF]) << (8 * k));
    if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mdl_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < nbytes(f); k++) mdl[(a + k) & 32'hFFFF] = d[8*k +: 8];
  endtask

  task automatic txn(input bit e0, input bit e3, input bit w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] wd, input int stall,
                     input string tag);
    bit          en [2];
    bit          done [2];
    int          held [2];
    int          exp_lat [2];
    bit          exp_err;
    logic [31:0] exp_rd;
    en[0] = e0; en[1] = e3;
    done[0] = !e0; done[1] = !e3;
    held[0] = 0; held[1] = 0;
    exp_lat[0] = 1; exp_lat[1] = WC + 1;
    exp_err = !legal(w, f, a);
    exp_rd  = (!exp_err && !w) ? mdl_load(f, a) : 32'd0;
    if (!exp_err && w) mdl_store(f, a, wd);
    @(negedge clk);
    wr = w; f3 = f; addr = a; wdata = wd; vld = {e3, e0};
    for (int d = 0; d < 2; d++) if (en[d]) check({tag, "/req_ready_idle"}, 32'(rr[d]), 32'd1);
    @(posedge clk);
    #1;
    vld = 2'b00;
    wr = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    for (int c = 1; c <= 40 && !(done[0] && done[1]); c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!done[d]) begin
          if (rrdy[d]) begin
            check({tag, "/valid_drop"}, 32'(rv[d]), 32'd0);
            check({tag, "/ready_back"}, 32'(rr[d]), 32'd1);
            rrdy[d] = 1'b0;
            done[d] = 1'b1;
          end else if (rv[d]) begin
            if (held[d] == 0) check({tag, "/latency"}, 32'(c), 32'(exp_lat[d]));
            check({tag, "/rdata"}, get_rd(d), exp_rd);
            check({tag, "/err"}, 32'(re[d]), 32'(exp_err));
            check({tag, "/req_ready_resp"}, 32'(rr[d]), 32'd0);
            if (held[d] >= stall) rrdy[d] = 1'b1;
            held[d]++;
          end else begin
            check({tag, "/req_ready_wait"}, 32'(rr[d]), 32'd0);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (!done[d]) begin
        check({tag, "/timeout"}, 32'd0, 32'd1);
        rrdy[d] = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "/req_ready"}, 32'(rr[d]), 32'd1);
    check({tag, "/resp_valid"}, 32'(rv[d]), 32'd0);
    check({tag, "/resp_rdata"}, get_rd(d), 32'd0);
    check({tag, "/resp_err"}, 32'(re[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    int          sel;
    for (int i = 0; i < 65536; i++) mdl[i] = 8'd0;
    rst_n_v = 2'b00; vld = 2'b00; rrdy = 2'b00;
    wr = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "rst0");
    check_reset_outputs(1, "rst3");
    rst_n_v = 2'b11;
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "idle0");
    check_reset_outputs(1, "idle3");

    for (int i = 0; i < 8; i++) txn(1, 1, 1, 3'd2, 32'h200 + 32'(4 * i), 32'd0, 0, "init");
    for (int i = 0; i < 4; i++) txn(1, 1, 1, 3'd2, 32'hFFF0 + 32'(4 * i), 32'd0, 0, "init");
    for (int i = 0; i < 4; i++) txn(1, 1, 1, 3'd2, 32'(4 * i), 32'd0, 0, "init");
    txn(1, 1, 1, 3'd2, 32'h104, 32'h0000_0000, 0, "init");

    txn(1, 1, 1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, "sw");
    txn(1, 1, 0, 3'd2, 32'h100, 32'd0, 0, "lw");
    check("model_lw", mdl_load(3'd2, 32'h100), 32'hDEAD_BEEF);
    txn(1, 1, 0, 3'd4, 32'h101, 32'd0, 0, "lbu");
    txn(1, 1, 0, 3'd0, 32'h103, 32'd0, 0, "lb");
    txn(1, 1, 0, 3'd1, 32'h102, 32'd0, 1, "lh");
    txn(1, 1, 0, 3'd5, 32'h100, 32'd0, 0, "lhu");
    txn(1, 1, 1, 3'd0, 32'h102, 32'h0000_0055, 0, "sb");
    txn(1, 1, 0, 3'd2, 32'h100, 32'd0, 0, "lw_sb");
    check("model_sb", mdl_load(3'd2, 32'h100), 32'hDE55_BEEF);
    txn(1, 1, 0, 3'd2, 32'h100, 32'd0, 2, "stall");
    txn(1, 1, 0, 3'd2, 32'h1234_0100, 32'd0, 0, "hi_bits");

    txn(1, 1, 1, 3'd2, 32'hFFFE, 32'h1122_3344, 0, "sw_wrap");
    txn(1, 1, 0, 3'd4, 32'hFFFE, 32'd0, 0, "wrap_b0");
    txn(1, 1, 0, 3'd4, 32'hFFFF, 32'd0, 0, "wrap_b1");
    txn(1, 1, 0, 3'd4, 32'h0000, 32'd0, 0, "wrap_b2");
    txn(1, 1, 0, 3'd4, 32'h0001, 32'd0, 0, "wrap_b3");
    txn(1, 1, 0, 3'd2, 32'hFFFE, 32'd0, 0, "lw_wrap");

    txn(1, 1, 0, 3'd3, 32'h100, 32'd0, 0, "ill_011");
    txn(1, 1, 1, 3'd6, 32'h100, 32'hFFFF_FFFF, 0, "ill_110");
    txn(1, 1, 1, 3'd4, 32'h100, 32'hFFFF_FFFF, 0, "ill_sbu");
    txn(1, 1, 0, 3'd2, 32'h100, 32'd0, 0, "after_ill");

    @(negedge clk);
    wr = 1'b1; f3 = 3'd2; addr = 32'h104; wdata = 32'hCAFE_BABE; vld = 2'b10;
    @(posedge clk);
    #1;
    vld = 2'b00;
    @(negedge clk);
    check("rstw/in_wait", 32'(rr[1]), 32'd0);
    rst_n_v[1] = 1'b0;
    #1;
    check_reset_outputs(1, "rstw");
    @(negedge clk);
    rst_n_v[1] = 1'b1;
    txn(1, 1, 0, 3'd2, 32'h104, 32'd0, 0, "rstw_mem");

    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(0, 2));
      a = (sel == 0) ? 32'h200 + $urandom_range(0, 28) :
          (sel == 1) ? 32'hFFF0 + $urandom_range(0, 15) : $urandom_range(0, 12);
      a = a | ({16'($urandom), 16'd0});
      f = 3'($urandom);
      txn(1, 1, 1'($urandom), f, a, $urandom, int'($urandom_range(0, 2)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
